store_size_rmw: RTL and testbench

STORE_SIZE_RMW -- requirements
Module: store_size_rmw

---
 rtl/store_size_rmw.sv | 246 ++++++++++++++++++++++++
 tb/tb_store_size_rmw.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/store_size_rmw.sv
// ---------------------------------------------------------------------------
// StoreSizeRmw -- sub-word store engine using read-modify-write
//
// Purpose:
//   Performs one store of a word, halfword or byte into a word-wide memory.
//   A word store is written directly. A halfword or byte store first reads the
//   containing word, merges the new lane into it, and then writes the whole
//   word back. Lanes are little-endian.
//
// Parameters:
//   RD_LAT     memory read latency in cycles (legal range 1..7).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle store request, honoured only while idle
//   ss_sel     store size: 00 word, 01 halfword, 10 byte, 11 word
//   addr       byte address of the store
//   wdata      source data; the low 16 / 8 bits are used for half / byte
//   mem_addr   word-aligned memory address (registered)
//   mem_rdata  memory read data
//   mem_wr     one-cycle memory write strobe (registered)
//   mem_wdata  merged word to write (registered, only meaningful with mem_wr)
//   busy       high whenever the engine is not idle (registered)
//   done       one-cycle completion pulse (registered)
//   misaligned only when STORE_ALIGN_CHECK_EN is defined: one-cycle flag that
//              accompanies done when a store was rejected as misaligned
//
// Build option:
//   STORE_ALIGN_CHECK_EN  when defined, a halfword at an odd address or a word
//                         at a non-multiple-of-4 address is rejected: no read,
//                         no write, done and misaligned pulse together.
//                         When undefined, the halfword lane is chosen by
//                         addr[1] alone and words ignore addr[1:0].
// ---------------------------------------------------------------------------
module store_size_rmw #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ss_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Store size encodings; 2'b11 falls through to word handling
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Value the read counter starts from so READ lasts exactly RD_LAT cycles
  localparam logic [2:0] READ_LAST = 3'(RD_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  readCnt_q, readCnt_d;
  logic        isHalf_q;
  logic        isByte_q;
  logic [1:0]  lane_q;
  logic [15:0] wdataLow_q;
  logic [31:0] memAddr_q;
  logic        memWr_q;
  logic [31:0] memWdata_q;
  logic        busy_q;
  logic        done_q;

  logic        isHalfIn;
  logic        isByteIn;
  logic        acceptStart;
  logic        badAlign;
  logic [31:0] mergeWord;
  logic [31:0] writeWord;

  // Decode the size of the incoming request. Anything that is neither half
  // nor byte is handled as a full word, which covers the 2'b11 encoding.
  always_comb begin
    isHalfIn = (ss_sel == SZ_HALF);
    isByteIn = (ss_sel == SZ_BYTE);
  end

  // Alignment check on the incoming request. Bytes can never be misaligned.
  // Without the check option every request is treated as aligned, so a half
  // just uses addr[1] and a word ignores the two low address bits.
`ifdef STORE_ALIGN_CHECK_EN
  always_comb begin
    badAlign = 1'b0;
    if (isHalfIn) begin
      badAlign = addr[0];
    end else if (!isByteIn) begin
      badAlign = (addr[1:0] != 2'b00);
    end
  end
`else
  assign badAlign = 1'b0;
`endif

  // Next-state logic. start is only looked at in IDLE, so a request that
  // arrives while busy is simply dropped. READ counts down RD_LAT cycles and
  // the read data is captured on the edge that leaves READ.
  always_comb begin
    state_d     = state_q;
    readCnt_d   = readCnt_q;
    acceptStart = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acceptStart = 1'b1;
          if (badAlign) begin
            state_d = DONE;
          end else if (isHalfIn || isByteIn) begin
            state_d   = READ;
            readCnt_d = READ_LAST;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        if (readCnt_q == 3'd0) begin
          state_d = WRITE;
        end else begin
          readCnt_d = readCnt_q - 3'd1;
        end
      end
      WRITE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane merge of the captured source data into the word coming back from
  // memory. Byte lane is addr[1:0]; half lane is addr[1] (0 = low half).
  always_comb begin
    mergeWord = mem_rdata;
    if (isByte_q) begin
      case (lane_q)
        2'd0:    mergeWord[7:0]   = wdataLow_q[7:0];
        2'd1:    mergeWord[15:8]  = wdataLow_q[7:0];
        2'd2:    mergeWord[23:16] = wdataLow_q[7:0];
        default: mergeWord[31:24] = wdataLow_q[7:0];
      endcase
    end else if (isHalf_q) begin
      if (lane_q[1]) begin
        mergeWord[31:16] = wdataLow_q;
      end else begin
        mergeWord[15:0] = wdataLow_q;
      end
    end
  end

  // A word store enters WRITE straight from IDLE and writes the request data
  // as-is; sub-word stores enter WRITE from READ with the merged word.
  always_comb begin
    writeWord = mergeWord;
    if (state_q == IDLE) begin
      writeWord = wdata;
    end
  end

  // State, read counter and request capture. Reset clears everything so an
  // aborted store leaves nothing behind to be written later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      readCnt_q  <= 3'd0;
      isHalf_q   <= 1'b0;
      isByte_q   <= 1'b0;
      lane_q     <= 2'd0;
      wdataLow_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      readCnt_q <= readCnt_d;
      if (acceptStart) begin
        isHalf_q   <= isHalfIn;
        isByte_q   <= isByteIn;
        lane_q     <= addr[1:0];
        wdataLow_q <= wdata[15:0];
      end
    end
  end

  // Registered outputs, decoded from the next state so that each output is
  // valid in the same cycle the FSM sits in the matching state. mem_addr
  // holds its value until the next accepted request; mem_wdata only updates
  // when a write is about to be issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memAddr_q  <= 32'd0;
      memWr_q    <= 1'b0;
      memWdata_q <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (acceptStart) begin
        memAddr_q <= {addr[31:2], 2'b00};
      end
      memWr_q <= (state_d == WRITE);
      if (state_d == WRITE) begin
        memWdata_q <= writeWord;
      end
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned_q;

  // The only way to reach DONE directly from IDLE is a rejected request, so
  // that transition is exactly when the misaligned flag should pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= (state_q == IDLE) && (state_d == DONE);
    end
  end

  assign misaligned = misaligned_q;
`endif

  assign mem_addr  = memAddr_q;
  assign mem_wr    = memWr_q;
  assign mem_wdata = memWdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_store_size_rmw.sv
// ---------------------------------------------------------------------------
// tb_store_size_rmw -- directed self-checking bench for store_size_rmw
//
// Two instances share clock, reset and request data: dut1 with RD_LAT=1 and
// dut3 with RD_LAT=3, each with its own start. Cycle k of a store is the
// k-th falling edge after the falling edge that raised start.
// ---------------------------------------------------------------------------
module tb_store_size_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic [1:0]  ssSel;
  logic [31:0] addr, wdata, memRdata;

  logic [31:0] memAddr1, memWdata1, memAddr3, memWdata3;
  logic        memWr1, busy1, done1, memWr3, busy3, done3;
`ifdef STORE_ALIGN_CHECK_EN
  logic        mis1, mis3;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  store_size_rmw #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ss_sel(ssSel), .addr(addr),
    .wdata(wdata), .mem_addr(memAddr1), .mem_rdata(memRdata), .mem_wr(memWr1),
    .mem_wdata(memWdata1), .busy(busy1), .done(done1)
`ifdef STORE_ALIGN_CHECK_EN
    , .misaligned(mis1)
`endif
  );

  store_size_rmw #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .ss_sel(ssSel), .addr(addr),
    .wdata(wdata), .mem_addr(memAddr3), .mem_rdata(memRdata), .mem_wr(memWr3),
    .mem_wdata(memWdata3), .busy(busy3), .done(done3)
`ifdef STORE_ALIGN_CHECK_EN
    , .misaligned(mis3)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one store on the selected instance (call on a falling edge) and
  // watches it for a fixed 12 cycles. extraAt raises start again in that
  // cycle to probe that requests are ignored while busy.
  task automatic applyStimulus(input int which, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input int extraAt,
                               output int wrCycle, output int wrCount,
                               output logic [31:0] wdSeen, output logic [31:0] maSeen,
                               output int doneCycle, output int misCycle);
    logic wr, dn, mis;
    ssSel    = sz;
    addr     = a;
    wdata    = wd;
    memRdata = rd;
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    wrCycle = -1; wrCount = 0; doneCycle = -1; misCycle = -1;
    wdSeen = 32'd0; maSeen = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      if (c == extraAt) begin
        if (which == 1) start1 = 1'b1; else start3 = 1'b1;
      end
      wr  = (which == 1) ? memWr1 : memWr3;
      dn  = (which == 1) ? done1 : done3;
      mis = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      mis = (which == 1) ? mis1 : mis3;
`endif
      if (wr) begin
        wrCount++;
        if (wrCycle < 0) begin
          wrCycle = c;
          wdSeen  = (which == 1) ? memWdata1 : memWdata3;
          maSeen  = (which == 1) ? memAddr1 : memAddr3;
        end
      end
      if (dn && doneCycle < 0) doneCycle = c;
      if (mis && misCycle < 0) misCycle = c;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wrC, wrN, dnC, misC, wrLate;
    logic [31:0] wdS, maS;

    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    ssSel = 2'b00; addr = 32'd0; wdata = 32'd0; memRdata = 32'd0;
    repeat (2) @(negedge clk);

    checkOutput("rst mem_addr", memAddr1, 32'd0);
    checkOutput("rst mem_wdata", memWdata1, 32'd0);
    checkOutput("rst mem_wr", {31'd0, memWr1}, 32'd0);
    checkOutput("rst busy", {31'd0, busy1}, 32'd0);
    checkOutput("rst done", {31'd0, done1}, 32'd0);

    // First request on the very first rising edge after reset release
    reset = 1'b0;
    applyStimulus(1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("word wr cycle", wrC, 32'd1);
    checkOutput("word wr count", wrN, 32'd1);
    checkOutput("word mem_addr", maS, 32'h0000_0010);
    checkOutput("word mem_wdata", wdS, 32'hDEAD_BEEF);
    checkOutput("word done cycle", dnC, 32'd2);
    checkOutput("word busy after", {31'd0, busy1}, 32'd0);

    applyStimulus(1, 2'b10, 32'h0000_0013, 32'h0000_00AB, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("byte3 wr cycle", wrC, 32'd2);
    checkOutput("byte3 mem_wdata", wdS, 32'hAB22_3344);
    checkOutput("byte3 mem_addr", maS, 32'h0000_0010);
    checkOutput("byte3 done cycle", dnC, 32'd3);
    checkOutput("mem_addr held", memAddr1, 32'h0000_0010);

    applyStimulus(1, 2'b10, 32'h0000_0040, 32'hFFFF_FF55, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("byte0 mem_wdata", wdS, 32'h1122_3355);
    applyStimulus(1, 2'b10, 32'h0000_0041, 32'h0000_0066, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("byte1 mem_wdata", wdS, 32'h1122_6644);
    applyStimulus(1, 2'b10, 32'h0000_0042, 32'h0000_0077, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("byte2 mem_wdata", wdS, 32'h1177_3344);

    applyStimulus(1, 2'b01, 32'h0000_0022, 32'hFFFF_CAFE, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("half hi mem_addr", maS, 32'h0000_0020);
    checkOutput("half hi mem_wdata", wdS, 32'hCAFE_3344);
    checkOutput("half hi wr cycle", wrC, 32'd2);
    applyStimulus(1, 2'b01, 32'h0000_0020, 32'h1234_BEEF, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("half lo mem_wdata", wdS, 32'h1122_BEEF);

    applyStimulus(1, 2'b11, 32'h0000_0034, 32'h0BAD_F00D, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("size11 wr cycle", wrC, 32'd1);
    checkOutput("size11 mem_wdata", wdS, 32'h0BAD_F00D);
    checkOutput("size11 mem_addr", maS, 32'h0000_0034);

    // RD_LAT=3 byte with a second request raised during READ
    applyStimulus(3, 2'b10, 32'h0000_0040, 32'h0000_0099, 32'hAABB_CCDD, 2, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("lat3 wr cycle", wrC, 32'd4);
    checkOutput("lat3 wr count", wrN, 32'd1);
    checkOutput("lat3 mem_wdata", wdS, 32'hAABB_CC99);
    checkOutput("lat3 done cycle", dnC, 32'd5);

    // Half at an odd address: rejected with the check, lower lane without it
    applyStimulus(1, 2'b01, 32'h0000_0021, 32'h0000_7777, 32'h1122_3344, 0, wrC, wrN, wdS, maS, dnC, misC);
`ifdef STORE_ALIGN_CHECK_EN
    checkOutput("misalign flag cycle", misC, 32'd1);
    checkOutput("misalign done cycle", dnC, 32'd1);
    checkOutput("misalign wr count", wrN, 32'd0);
`else
    checkOutput("odd half wr cycle", wrC, 32'd2);
    checkOutput("odd half mem_addr", maS, 32'h0000_0020);
    checkOutput("odd half mem_wdata", wdS, 32'h1122_7777);
    checkOutput("odd half done cycle", dnC, 32'd3);
`endif

    // Reset asserted mid-cycle while dut3 is in READ
    ssSel = 2'b10; addr = 32'h0000_0040; wdata = 32'h0000_0011; memRdata = 32'h0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort busy", {31'd0, busy3}, 32'd0);
    checkOutput("abort mem_wr", {31'd0, memWr3}, 32'd0);
    checkOutput("abort mem_addr", memAddr3, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wrLate = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (memWr3) wrLate++;
    end
    checkOutput("abort late writes", wrLate, 32'd0);

    applyStimulus(3, 2'b10, 32'h0000_0043, 32'h0000_0022, 32'h0000_0000, 0, wrC, wrN, wdS, maS, dnC, misC);
    checkOutput("post-abort wr cycle", wrC, 32'd4);
    checkOutput("post-abort mem_wdata", wdS, 32'h2200_0000);
    checkOutput("post-abort wr count", wrN, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
